expr_checker: RTL and testbench

- Streaming ASCII arithmetic-expression recogniser, one character per accepted cycle.
- Grammar: operand (op operand)*. Operand is a multi-digit decimal number or a parenthesised sub-expression. Op is one of + - * /.
- `out` flags that the prefix received so far is a complete, well-formed expression.
- Sits behind the character input path of the calculator/console datapath. Error reporting pinpoints the first offending character.

---
 rtl/expr_chk_pkg.sv | 36 +++
 rtl/expr_chk_classify.sv | 31 +++
 rtl/expr_checker.sv | 161 ++++++++++++++++
 tb/tb_expr_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_chk_pkg.sv
// expr_chk_pkg
//   Shared types and constants for the streaming expression checker.
//   state_t   : recogniser FSM states
//   cclass_t  : character classes produced by expr_chk_classify
//   CH_*      : ASCII codes of the characters the grammar cares about
//   CNT_W     : width of the digit counter and the depth counter
package expr_chk_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_NUM   = 2'd1,
        S_CLOSE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_DIGIT = 3'd0,
        C_OP    = 3'd1,
        C_LP    = 3'd2,
        C_RP    = 3'd3,
        C_OTHER = 3'd4
    } cclass_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;

    // MAX_DIGITS and DEPTH are both capped at 15
    localparam int CNT_W = 4;

endpackage

// File: rtl/expr_chk_classify.sv
// expr_chk_classify
//   Purely combinational ASCII character classifier.
//   Macro EXPR_CHK_PAREN_EN: when undefined, '(' and ')' fall into C_OTHER,
//   so the checker sees them as illegal characters.
// Ports:
//   ch_i  [7:0]  character to classify
//   cls_o        character class
module expr_chk_classify
    import expr_chk_pkg::*;
(
    input  logic [7:0] ch_i,
    output cclass_t    cls_o
);

    always_comb begin
        cls_o = C_OTHER;
        if (ch_i >= CH_0 && ch_i <= CH_9) begin
            cls_o = C_DIGIT;
        end else if (ch_i == CH_PLUS || ch_i == CH_MINUS ||
                     ch_i == CH_STAR || ch_i == CH_SLASH) begin
            cls_o = C_OP;
`ifdef EXPR_CHK_PAREN_EN
        end else if (ch_i == CH_LP) begin
            cls_o = C_LP;
        end else if (ch_i == CH_RP) begin
            cls_o = C_RP;
`endif
        end
    end

endmodule

// File: rtl/expr_checker.sv
// expr_checker
//   Streaming recogniser for ASCII arithmetic expressions of the form
//   operand (op operand)*, where an operand is a decimal number of at most
//   MAX_DIGITS digits or a parenthesised sub-expression nested at most DEPTH
//   deep. One character is consumed per clk edge with in_valid=1.
//   Macro EXPR_CHK_PAREN_EN enables parenthesis support; without it the
//   grammar reduces to number (op number)* and depth is tied to 0.
// Ports:
//   clk       rising-edge clock
//   clr       asynchronous active-high reset
//   in_valid  character strobe
//   in        ASCII character
//   out       accepted prefix is a complete valid expression
//   err       sticky error flag
//   depth     current open-parenthesis count
//   err_pos   0-based index of the first offending character (valid with err)
//
// state   | meaning
// S_START | expecting an operand (digit or '(')
// S_NUM   | inside a number
// S_CLOSE | just after ')', expecting an op or another ')'
// S_ERR   | error seen, absorbing until clr
module expr_checker
    import expr_chk_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int DEPTH      = 4,
    parameter int POS_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic             out,
    output logic             err,
    output logic [3:0]       depth,
    output logic [POS_W-1:0] err_pos
);

    localparam logic [CNT_W-1:0] DIG_MAX   = 4'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] DEPTH_MAX = 4'(DEPTH);

    cclass_t          cls;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] err_pos_q;
    logic             out_q, out_d;
    logic             err_q;
    logic             fail;

    expr_chk_classify u_classify (
        .ch_i  (in),
        .cls_o (cls)
    );

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        depth_d = depth_q;
        fail    = 1'b0;
        case (state_q)
            S_START: begin
                case (cls)
                    C_DIGIT: begin
                        state_d = S_NUM;
                        dcnt_d  = 4'd1;
                    end
                    C_LP: begin
                        if (depth_q == DEPTH_MAX) fail = 1'b1;
                        else depth_d = depth_q + 4'd1;
                    end
                    default: fail = 1'b1;
                endcase
            end
            S_NUM: begin
                case (cls)
                    C_DIGIT: begin
                        if (dcnt_q == DIG_MAX) fail = 1'b1;
                        else dcnt_d = dcnt_q + 4'd1;
                    end
                    C_OP: begin
                        state_d = S_START;
                        dcnt_d  = '0;
                    end
                    C_RP: begin
                        if (depth_q == '0) begin
                            fail = 1'b1;
                        end else begin
                            state_d = S_CLOSE;
                            dcnt_d  = '0;
                            depth_d = depth_q - 4'd1;
                        end
                    end
                    default: fail = 1'b1;
                endcase
            end
            S_CLOSE: begin
                case (cls)
                    C_OP: state_d = S_START;
                    C_RP: begin
                        if (depth_q == '0) fail = 1'b1;
                        else depth_d = depth_q - 4'd1;
                    end
                    default: fail = 1'b1;
                endcase
            end
            S_ERR: begin
            end
            default: fail = 1'b1;
        endcase

        // an error freezes the counters at their pre-error values
        if (fail) begin
            state_d = S_ERR;
            dcnt_d  = dcnt_q;
            depth_d = depth_q;
        end

        out_d = (state_d == S_NUM || state_d == S_CLOSE) && (depth_d == '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_START;
            dcnt_q    <= '0;
            pos_q     <= '0;
            out_q     <= 1'b0;
            err_q     <= 1'b0;
            err_pos_q <= '0;
        end else if (in_valid) begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            out_q   <= out_d;
            if (fail) begin
                err_q     <= 1'b1;
                err_pos_q <= pos_q;
            end
            if (pos_q != '1) pos_q <= pos_q + 1'b1;
        end
    end

`ifdef EXPR_CHK_PAREN_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) depth_q <= '0;
        else if (in_valid) depth_q <= depth_d;
    end
`else
    // parentheses never reach the FSM, so depth_d can only equal depth_q
    logic unused_depth_d;
    assign depth_q        = '0;
    assign unused_depth_d = ^depth_d;
`endif

    assign out     = out_q;
    assign err     = err_q;
    assign depth   = depth_q;
    assign err_pos = err_pos_q;

endmodule

// File: tb/tb_expr_checker.sv
// tb_expr_checker
//   Self-checking bench for expr_checker (MAX_DIGITS=4, DEPTH=2, POS_W=8).
//   Works with and without EXPR_CHK_PAREN_EN. The reference model judges each
//   character by its predecessor and running digit/paren counts.
module tb_expr_checker;

    localparam int MAXD = 4;
    localparam int DEP  = 2;
    localparam int PW   = 8;
    localparam int POS_MAX = (1 << PW) - 1;
`ifdef EXPR_CHK_PAREN_EN
    localparam bit PAREN = 1'b1;
`else
    localparam bit PAREN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          in_valid;
    logic [7:0]    in;
    logic          out;
    logic          err;
    logic [3:0]    depth;
    logic [PW-1:0] err_pos;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           m_err, m_out, m_has_prev;
    byte unsigned m_prev;
    int           m_run, m_depth, m_errpos, m_pos;

    expr_checker #(
        .MAX_DIGITS (MAXD),
        .DEPTH      (DEP),
        .POS_W      (PW)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .out      (out),
        .err      (err),
        .depth    (depth),
        .err_pos  (err_pos)
    );

    always #5 clk = ~clk;

    function automatic bit is_digit(input byte unsigned c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    task automatic model_reset();
        m_err = 0; m_out = 0; m_has_prev = 0; m_prev = 0;
        m_run = 0; m_depth = 0; m_errpos = 0; m_pos = 0;
    endtask

    task automatic model_step(input byte unsigned c);
        bit dig, op, lp, rp, ends_operand, bad;
        dig = is_digit(c);
        op  = c inside {8'h2B, 8'h2D, 8'h2A, 8'h2F};
        lp  = PAREN && c == 8'h28;
        rp  = PAREN && c == 8'h29;
        ends_operand = m_has_prev && (is_digit(m_prev) || m_prev == 8'h29);
        if (!m_err) begin
            bad = 0;
            if (dig) begin
                m_run = (m_has_prev && is_digit(m_prev)) ? m_run + 1 : 1;
                bad = (m_has_prev && m_prev == 8'h29) || m_run > MAXD;
            end else if (op) bad = !ends_operand;
            else if (lp)     bad = ends_operand || m_depth == DEP;
            else if (rp)     bad = !ends_operand || m_depth == 0;
            else             bad = 1;
            if (bad) begin
                m_err = 1; m_errpos = m_pos; m_out = 0;
            end else begin
                if (lp) m_depth++;
                if (rp) m_depth--;
                m_prev = c; m_has_prev = 1;
                m_out = (dig || rp) && m_depth == 0;
            end
        end
        if (m_pos < POS_MAX) m_pos++;
    endtask

    function automatic logic [13:0] exp_vec();
        return {m_out, m_err, 4'(m_depth), 8'(m_errpos)};
    endfunction

    task automatic do_reset();
        in_valid = 0;
        clr = 1;
        @(negedge clk);
        @(negedge clk);
        clr = 0;
        model_reset();
    endtask

    // drive one character for exactly one rising edge, return 1 after it
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in = c;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in = 8'($urandom);
            @(posedge clk);
        end
        #1;
    endtask

    function automatic logic [7:0] pick_char();
        logic [7:0] ops [4];
        int r;
        bit ends_operand;
        ops = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
        r = $urandom_range(0, 99);
        ends_operand = m_has_prev && (is_digit(m_prev) || m_prev == 8'h29);
        if (r < 8) return 8'($urandom);
        if (!ends_operand) return (r < 75) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'h28;
        if (r < 50) return 8'(8'h30 + $urandom_range(0, 9));
        if (r < 80) return ops[$urandom_range(0, 3)];
        return 8'h29;
    endfunction

    task automatic test_reset();
        clr = 1; in_valid = 0; in = 8'h31;
        #12;
        checks++;
        if ({out, err, depth, err_pos} !== 14'b0) begin
            errors++;
            $display("FAIL reset: got %b expected %b", {out, err, depth, err_pos}, 14'b0);
        end
        @(negedge clk);
        clr = 0;
        model_reset();
    endtask

    task automatic test_basic();
        string s;
        bit exp_out [4];
        s = "12+3";
        exp_out = '{1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            model_step(s[i]);
            checks++;
            if ({out, err, depth, err_pos} !== exp_vec()) begin
                errors++;
                $display("FAIL basic_model[%0d]: got %b expected %b", i, {out, err, depth, err_pos}, exp_vec());
            end
            checks++;
            if ({out, err, depth} !== {exp_out[i], 1'b0, 4'd0}) begin
                errors++;
                $display("FAIL basic_out[%0d]: got out=%b err=%b depth=%0d expected out=%b err=0 depth=0",
                         i, out, err, depth, exp_out[i]);
            end
        end
    endtask

    task automatic test_parens();
        string s;
        int dexp [9];
        s = "(1+(2*3))";
        dexp = '{1, 1, 1, 2, 2, 2, 2, 1, 0};
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            model_step(s[i]);
            checks++;
            if ({out, err, depth, err_pos} !== exp_vec()) begin
                errors++;
                $display("FAIL paren_model[%0d]: got %b expected %b", i, {out, err, depth, err_pos}, exp_vec());
            end
            checks++;
            if (PAREN) begin
                if ({out, err, depth} !== {(i == 8), 1'b0, 4'(dexp[i])}) begin
                    errors++;
                    $display("FAIL paren_depth[%0d]: got out=%b err=%b depth=%0d expected out=%b err=0 depth=%0d",
                             i, out, err, depth, (i == 8), dexp[i]);
                end
            end else begin
                if ({out, err, depth, err_pos} !== {1'b0, 1'b1, 4'd0, 8'd0}) begin
                    errors++;
                    $display("FAIL noparen[%0d]: got out=%b err=%b depth=%0d err_pos=%0d expected 0 1 0 0",
                             i, out, err, depth, err_pos);
                end
            end
        end
    endtask

    task automatic test_max_digits();
        string s;
        s = "12345+1";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            model_step(s[i]);
            checks++;
            if ({out, err, depth, err_pos} !== exp_vec()) begin
                errors++;
                $display("FAIL digits_model[%0d]: got %b expected %b", i, {out, err, depth, err_pos}, exp_vec());
            end
            checks++;
            if (i < 4) begin
                if ({out, err} !== 2'b10) begin
                    errors++;
                    $display("FAIL digits_ok[%0d]: got out=%b err=%b expected out=1 err=0", i, out, err);
                end
            end else if ({out, err, err_pos} !== {1'b0, 1'b1, 8'd4}) begin
                errors++;
                $display("FAIL digits_err[%0d]: got out=%b err=%b err_pos=%0d expected 0 1 4", i, out, err, err_pos);
            end
        end
    endtask

    task automatic test_errors();
        string cases [3];
        int    epos  [3];
        int    edep  [3];
        cases = '{")", "(((", "1+*"};
        epos  = PAREN ? '{0, 2, 2} : '{0, 0, 2};
        edep  = PAREN ? '{0, 2, 0} : '{0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            for (int i = 0; i < cases[k].len(); i++) begin
                send(cases[k][i]);
                model_step(cases[k][i]);
                checks++;
                if ({out, err, depth, err_pos} !== exp_vec()) begin
                    errors++;
                    $display("FAIL err%0d_model[%0d]: got %b expected %b", k, i, {out, err, depth, err_pos}, exp_vec());
                end
            end
            checks++;
            if ({out, err, depth, err_pos} !== {1'b0, 1'b1, 4'(edep[k]), 8'(epos[k])}) begin
                errors++;
                $display("FAIL err%0d_final: got out=%b err=%b depth=%0d err_pos=%0d expected 0 1 %0d %0d",
                         k, out, err, depth, err_pos, edep[k], epos[k]);
            end
        end
    endtask

    task automatic test_gapped();
        string s;
        logic [13:0] ref_v [3];
        s = "7+8";
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            ref_v[i] = {out, err, depth, err_pos};
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(s[i]);
            model_step(s[i]);
            idle(2);
            checks++;
            if ({out, err, depth, err_pos} !== exp_vec() || {out, err, depth, err_pos} !== ref_v[i]) begin
                errors++;
                $display("FAIL gapped[%0d]: got %b expected %b (back-to-back %b)",
                         i, {out, err, depth, err_pos}, exp_vec(), ref_v[i]);
            end
        end
        send(8'h39);
        send(8'h2A);
        #2 clr = 1;
        #1;
        checks++;
        if ({out, err, depth, err_pos} !== 14'b0) begin
            errors++;
            $display("FAIL midclr: got %b expected %b", {out, err, depth, err_pos}, 14'b0);
        end
        @(negedge clk);
        clr = 0;
        model_reset();
        send(8'h35);
        model_step(8'h35);
        checks++;
        if ({out, err} !== 2'b10 || {out, err, depth, err_pos} !== exp_vec()) begin
            errors++;
            $display("FAIL restart: got %b expected %b", {out, err, depth, err_pos}, exp_vec());
        end
        send(8'h3F);
        model_step(8'h3F);
        checks++;
        if ({err, err_pos} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL restart_pos: got err=%b err_pos=%0d expected err=1 err_pos=1", err, err_pos);
        end
    endtask

    task automatic test_pos_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 8'h31 : 8'h2B);
            model_step((i % 2 == 0) ? 8'h31 : 8'h2B);
        end
        send(8'h20);
        model_step(8'h20);
        checks++;
        if ({out, err, depth, err_pos} !== exp_vec() || err_pos !== 8'hFF) begin
            errors++;
            $display("FAIL pos_sat: got %b expected %b", {out, err, depth, err_pos}, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        int len, gap;
        for (int k = 0; k < 60; k++) begin
            do_reset();
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                c = pick_char();
                send(c);
                model_step(c);
                gap = $urandom_range(0, 2);
                if (gap != 0) idle(gap);
                checks++;
                if ({out, err, depth, err_pos} !== exp_vec()) begin
                    errors++;
                    $display("FAIL random[%0d.%0d] char=%02h: got %b expected %b",
                             k, i, c, {out, err, depth, err_pos}, exp_vec());
                end
            end
        end
    endtask

    initial begin
        clr = 1;
        in_valid = 0;
        in = 8'h00;
        model_reset();
        test_reset();
        test_basic();
        test_parens();
        test_max_digits();
        test_errors();
        test_gapped();
        test_pos_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
